abs_diff_sad_ctrl: RTL and testbench
====================================

ABS_DIFF_SAD_CTRL -- requirements
Module: abs_diff_sad_ctrl

Interface
- REQ-001 SHALL have parameter DW, default 3, giving the operand width in bits.
- REQ-002 SHALL have parameter CNT_W, default 4, giving the block-length counter width in bits.
- REQ-003 SHALL have parameter ACC_W, default DW+CNT_W, giving the accumulator and result width in bits.
- REQ-004 SHALL have port clk  input  1  sole clock, with all logic on the rising edge.
- REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
- REQ-006 SHALL have port cfg_len  input  CNT_W  number of operand pairs per block.
- REQ-007 SHALL have port in_valid  input  1  operand pair valid.
- REQ-008 SHALL have port in_ready  output  1  block can accept an operand pair.
- REQ-009 SHALL have port in_a  input  DW  unsigned operand A.
- REQ-010 SHALL have port in_b  input  DW  unsigned operand B.
- REQ-011 SHALL have port out_valid  output  1  block result valid.
- REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
- REQ-013 SHALL have port out_sad  output  ACC_W  sum of |A-B| over the block.
- REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
- REQ-015 SHALL accept an input pair only when in_valid and in_ready are both 1 on a rising edge (an "accept").
- REQ-016 SHALL compute each term as the exact unsigned |in_a - in_b| at DW bits, zero-extended to ACC_W before accumulation.
- REQ-017 SHALL implement three states: IDLE, ACCUM and DONE.
- REQ-018 IDLE SHALL drive in_ready=1, out_valid=0 and busy=0.
- REQ-019 On an accept in IDLE, the block SHALL do all of the following:
  - latch len = (cfg_len==0 ? 1 : cfg_len);
  - set acc = term;
  - set cnt = 1;
  - go to DONE if len==1, otherwise go to ACCUM.
- REQ-020 ACCUM SHALL drive in_ready=1, out_valid=0 and busy=1.
- REQ-021 On each accept in ACCUM, the block SHALL set acc += term and cnt += 1, and go to DONE when the new cnt equals len.
- REQ-022 DONE SHALL drive in_ready=0, out_valid=1, busy=1 and out_sad=acc.
- REQ-023 On out_valid and out_ready both 1 in DONE, the block SHALL clear acc and cnt and go to IDLE.
- REQ-024 out_valid SHALL rise on the cycle after the accept of the final pair, giving a latency of 1 cycle.
- REQ-025 The result handshake SHALL take at least 1 cycle, so back-to-back blocks have a 1-cycle in_ready=0 bubble.
- REQ-026 While out_valid=1 and out_ready=0, out_sad and out_valid SHALL remain stable for any duration.
- REQ-027 cfg_len SHALL be sampled only at the first accept of a block; changes to it mid-block SHALL be ignored.
- REQ-028 When in_valid is low in ACCUM, the block SHALL hold acc and cnt, with no timeout.
- REQ-029 in_a and in_b SHALL be ignored on any cycle without an accept.
- REQ-030 acc SHALL never overflow: the maximum value (2^DW-1)*(2^CNT_W-1) fits in ACC_W bits, and no saturation logic is required.
- REQ-031 out_sad SHALL read 0 whenever out_valid=0.
- REQ-032 out_ready asserted outside DONE SHALL have no effect.

Reset
- REQ-033 When rst=1 on a rising edge, the block SHALL set the state to IDLE, acc=0, cnt=0 and len=1, overriding any simultaneous handshake.
- REQ-034 Output values in reset and on the cycle after reset SHALL be in_ready=1, out_valid=0, out_sad=0 and busy=0.
- REQ-035 Reset mid-block in ACCUM or DONE SHALL discard the partial or pending result, and the next accept SHALL start a fresh block.

Verification
- REQ-036 The bench SHALL cover: cfg_len=4, pairs (7,0),(0,7),(3,5),(5,5) -> out_valid=1 one cycle after the 4th accept, with out_sad=16.
- REQ-037 The bench SHALL cover: cfg_len=1, pair (2,6) -> next cycle DONE with out_sad=4; cfg_len=0, pair (6,1) -> out_sad=5 after a single pair.
- REQ-038 The bench SHALL cover: cfg_len=15, all pairs (7,0) -> out_sad=105; also cfg_len changed to 2 after the 1st accept -> block still takes 15 pairs.
- REQ-039 The bench SHALL cover backpressure: out_ready=0 for 3 cycles in DONE -> out_sad stable and in_ready=0 throughout, with IDLE entered on the cycle after out_ready=1.
- REQ-040 The bench SHALL cover gaps: cfg_len=3 with in_valid gaps of 2 cycles between pairs (1,4),(4,1),(0,0) -> out_sad=6, with gaps not counted.
- REQ-041 The bench SHALL cover reset mid-block: rst pulsed after 2 of 4 pairs -> in_ready=1 and out_valid=0 next cycle; a new block cfg_len=1 with (0,3) -> out_sad=3.

Source files
------------

// File: rtl/abs_diff_sad_ctrl.sv
// Sum-of-absolute-differences block controller: accumulates |A-B| over a
// configurable number of operand pairs and presents the total with a valid/ready handshake.
module abs_diff_sad_ctrl #(
   parameter int DW    = 3,
   parameter int CNT_W = 4,
   parameter int ACC_W = DW + CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sad,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [ACC_W-1:0] acc_r, acc_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] len_r, len_s;
   logic             accept_s;
   logic [ACC_W-1:0] term_s;

   function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   // Output decode from the state register; the result bus is forced to zero outside DONE.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_sad   = {ACC_W{1'b0}};
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_sad   = acc_r;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign accept_s = in_valid & in_ready;
   assign term_s   = {{(ACC_W-DW){1'b0}}, abs_diff(in_a, in_b)};

   // Next-state, accumulator, counter and latched length.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      len_s   = len_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               // A zero length is treated as a single-pair block.
               len_s = (cfg_len == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_len;
               acc_s = term_s;
               cnt_s = {{(CNT_W-1){1'b0}}, 1'b1};
               if (len_s == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_s = DONE;
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               acc_s = acc_r + term_s;
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_s == len_r) begin
                  state_s = DONE;
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = ACCUM;
            end
         end
         DONE: begin
            if (out_ready) begin
               acc_s   = {ACC_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            len_s   = {{(CNT_W-1){1'b0}}, 1'b1};
         end
      endcase
   end

   // State and datapath registers; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         len_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         len_r   <= len_s;
      end
   end

endmodule

// File: tb/tb_abs_diff_sad_ctrl.sv
// Scoreboard bench for abs_diff_sad_ctrl: stimulus pushes expected sums, a
// negedge monitor pops and compares them on every result handshake.
module tb_abs_diff_sad_ctrl;
   localparam int DW    = 3;
   localparam int CNT_W = 4;
   localparam int ACC_W = DW + CNT_W;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] cfg_len;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_a;
   logic [DW-1:0]    in_b;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sad;
   logic             busy;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic             mon_en  = 1'b0;
   logic [ACC_W-1:0] sb_q[$];

   abs_diff_sad_ctrl #(.DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: compare each handshaken result against the scoreboard, and check the idle bus is zero.
   always @(negedge clk) begin : monitor
      logic [ACC_W-1:0] e;
      if (mon_en) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got out_sad=%0d, required no result at %0t", out_sad, $time);
            end else begin
               e = sb_q.pop_front();
               chk("sb_sad", {25'd0, out_sad}, {25'd0, e});
            end
         end else if (!out_valid) begin
            chk("sad_zero", {25'd0, out_sad}, 32'd0);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the pair.
   task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int w;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      w        = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0, required 1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = DW'($urandom_range(0, 7));
      in_b     = DW'($urandom_range(0, 7));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = 3'd0; in_b = 3'd0;
      cfg_len = 4'd0; out_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sad", {25'd0, out_sad}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // Four-pair block: 7+7+2+0 = 16
      cfg_len = 4'd4;
      sb_q.push_back(7'd16);
      send_pair(3'd7, 3'd0);
      chk("busy_accum", {31'd0, busy}, 32'd1);
      send_pair(3'd0, 3'd7);
      send_pair(3'd3, 3'd5);
      chk("valid_before_last", {31'd0, out_valid}, 32'd0);
      send_pair(3'd5, 3'd5);
      chk("lat4_valid", {31'd0, out_valid}, 32'd1);
      chk("lat4_in_ready", {31'd0, in_ready}, 32'd0);

      // Single-pair blocks, including zero length treated as one
      cfg_len = 4'd1;
      sb_q.push_back(7'd4);
      send_pair(3'd2, 3'd6);
      chk("len1_valid", {31'd0, out_valid}, 32'd1);
      cfg_len = 4'd0;
      sb_q.push_back(7'd5);
      send_pair(3'd6, 3'd1);
      chk("len0_valid", {31'd0, out_valid}, 32'd1);

      // Maximum length, maximum term: 15*7 = 105
      cfg_len = 4'd15;
      sb_q.push_back(7'd105);
      for (int i = 0; i < 15; i++) send_pair(3'd7, 3'd0);
      chk("len15_valid", {31'd0, out_valid}, 32'd1);

      // cfg_len changed after the first accept must be ignored
      cfg_len = 4'd15;
      sb_q.push_back(7'd105);
      send_pair(3'd7, 3'd0);
      cfg_len = 4'd2;
      send_pair(3'd0, 3'd7);
      chk("len_latched", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 13; i++) send_pair(3'd7, 3'd0);
      chk("len_latched_done", {31'd0, out_valid}, 32'd1);

      // Backpressure: result held stable for 3 cycles
      idle_cycles(2);
      out_ready = 1'b0;
      cfg_len   = 4'd2;
      sb_q.push_back(7'd3);
      send_pair(3'd1, 3'd0);
      send_pair(3'd0, 3'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sad", {25'd0, out_sad}, 32'd3);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);

      // Gaps between pairs are not counted: 3+3+0 = 6
      cfg_len = 4'd3;
      sb_q.push_back(7'd6);
      send_pair(3'd1, 3'd4);
      idle_cycles(2);
      send_pair(3'd4, 3'd1);
      idle_cycles(2);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      chk("gap_valid", {31'd0, out_valid}, 32'd0);
      send_pair(3'd0, 3'd0);
      chk("gap_done_valid", {31'd0, out_valid}, 32'd1);

      // Reset in DONE discards the pending result
      idle_cycles(2);
      out_ready = 1'b0;
      cfg_len   = 4'd1;
      send_pair(3'd1, 3'd1);
      idle_cycles(1);
      rst = 1'b1;
      idle_cycles(1);
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rst_done_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_done_in_ready", {31'd0, in_ready}, 32'd1);

      // Reset mid-block in ACCUM, then a fresh single-pair block
      cfg_len = 4'd4;
      send_pair(3'd3, 3'd0);
      send_pair(3'd0, 3'd3);
      rst = 1'b1;
      idle_cycles(1);
      rst = 1'b0;
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      cfg_len = 4'd1;
      sb_q.push_back(7'd3);
      send_pair(3'd0, 3'd3);
      chk("fresh_valid", {31'd0, out_valid}, 32'd1);

      idle_cycles(4);
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
